// File: rtl/tx_sym_source_pkg.sv
// Shared constants for the transmit symbol source: LFSR polynomial, Gray 4-ASK
// symbol codes, default levels in 1s17 and the enable-divider defaults.
package tx_sym_source_pkg;

  localparam int LFSR_LEN = 22;
  localparam int TAP_A    = 21;
  localparam int TAP_B    = 20;
  localparam logic [LFSR_LEN-1:0] LFSR_ONE = 22'h000001;

  typedef enum logic [1:0] {
    SYM_NEG_HI = 2'b00,
    SYM_NEG_LO = 2'b01,
    SYM_POS_LO = 2'b11,
    SYM_POS_HI = 2'b10
  } gray_sym_e;

  localparam int DEF_LVL_HI = 98304;  // 0.75 in 1s17
  localparam int DEF_LVL_LO = 32768;  // 0.25 in 1s17

  localparam int DEF_SAM_DIV  = 4;
  localparam int DEF_SYM_DIV  = 4;
  localparam int SYS_CLK2_DIV = 2;

  // One Fibonacci step of x^22 + x^21 + 1; the new bit enters at bit 0.
  function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
    return {s[LFSR_LEN-2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction

endpackage

// File: rtl/tx_sym_source_clk_en_gen.sv
// Free-running phase counter with registered half-rate, sample and symbol
// enables. The *_tick outputs flag the edge on which those enables get set.
module clk_en_gen #(
  parameter int SAM_DIV = 4,
  parameter int SYM_DIV = 4
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic sys_clk2_en,
  output logic sam_clk_en,
  output logic sym_clk_en,
  output logic sam_tick,
  output logic sym_tick
);

  localparam int N  = SAM_DIV * SYM_DIV;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] SAM_MASK = CW'(SAM_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic          advance;

  // N is a power of two, so the counter wraps by natural overflow.
  assign advance  = enable & ~restart;
  assign sam_tick = advance & ((cnt & SAM_MASK) == SAM_MASK);
  assign sym_tick = advance & (cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      sys_clk2_en <= 1'b0;
      sam_clk_en  <= 1'b0;
      sym_clk_en  <= 1'b0;
    end else if (restart) begin
      cnt         <= '0;
      sys_clk2_en <= 1'b0;
      sam_clk_en  <= 1'b0;
      sym_clk_en  <= 1'b0;
    end else if (enable) begin
      cnt         <= cnt + CW'(1);
      sys_clk2_en <= cnt[0];
      sam_clk_en  <= sam_tick;
      sym_clk_en  <= sym_tick;
    end else begin
      sys_clk2_en <= 1'b0;
      sam_clk_en  <= 1'b0;
      sym_clk_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_sym_source.sv
// PRBS 4-ASK source: two LFSR bits per symbol, Gray-mapped to a 1s17 level and
// emitted on each sample enable, zero-stuffed or held across the symbol.
module tx_sym_source
  import tx_sym_source_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int SAM_DIV    = DEF_SAM_DIV,
  parameter int SYM_DIV    = DEF_SYM_DIV,
  parameter int LVL_HI     = DEF_LVL_HI,
  parameter int LVL_LO     = DEF_LVL_LO,
  parameter int ZERO_STUFF = 1
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load_seed,
  input  logic [LFSR_LEN-1:0]     seed,
  output logic                    sys_clk2_en,
  output logic                    sam_clk_en,
  output logic                    sym_clk_en,
  output logic signed [WIDTH-1:0] x_out,
  output logic [1:0]              sym_idx
);

  localparam logic signed [WIDTH-1:0] X_POS_HI = WIDTH'(LVL_HI);
  localparam logic signed [WIDTH-1:0] X_POS_LO = WIDTH'(LVL_LO);
  localparam logic signed [WIDTH-1:0] X_NEG_LO = WIDTH'(-LVL_LO);
  localparam logic signed [WIDTH-1:0] X_NEG_HI = WIDTH'(-LVL_HI);

  logic                sam_tick;
  logic                sym_tick;
  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] lfsr_1;
  logic [LFSR_LEN-1:0] lfsr_2;
  logic [1:0]          sym_bits;

  clk_en_gen #(
    .SAM_DIV (SAM_DIV),
    .SYM_DIV (SYM_DIV)
  ) u_clk_en_gen (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .restart     (load_seed),
    .sys_clk2_en (sys_clk2_en),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .sam_tick    (sam_tick),
    .sym_tick    (sym_tick)
  );

  // Two steps per symbol; b1 is the first generated bit and lands in the MSB.
  assign lfsr_1   = lfsr_step(lfsr);
  assign lfsr_2   = lfsr_step(lfsr_1);
  assign sym_bits = {lfsr_1[0], lfsr_2[0]};

  function automatic logic signed [WIDTH-1:0] map_level(input logic [1:0] s);
    case (gray_sym_e'(s))
      SYM_NEG_HI: return X_NEG_HI;
      SYM_NEG_LO: return X_NEG_LO;
      SYM_POS_LO: return X_POS_LO;
      default:    return X_POS_HI;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr    <= LFSR_ONE;
      x_out   <= '0;
      sym_idx <= '0;
    end else if (load_seed) begin
      lfsr  <= (seed == '0) ? LFSR_ONE : seed;
      x_out <= '0;
    end else begin
      if (sym_tick) begin
        lfsr <= lfsr_2;
      end
      if (sam_tick) begin
        if (sym_tick) begin
          x_out   <= map_level(sym_bits);
          sym_idx <= sym_bits;
        end else if (ZERO_STUFF != 0) begin
          x_out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_sym_source.sv
// Bench for tx_sym_source: zero-stuffed and held instances share stimulus and
// are compared every cycle against a per-sample behavioural model.
module tb_tx_sym_source;

  localparam int SAM = 4;
  localparam int SYM = 4;
  localparam int N   = SAM * SYM;
  localparam int HI  = 98304;
  localparam int LO  = 32768;

  logic        sys_clk   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b0;
  logic        load_seed = 1'b0;
  logic [21:0] seed      = '0;

  logic        z_sys2, z_sam, z_sym;
  logic [17:0] z_x;
  logic [1:0]  z_idx;
  logic        h_sys2, h_sam, h_sym;
  logic [17:0] h_x;
  logic [1:0]  h_idx;

  int checks   = 0;
  int failures = 0;

  // model state
  int          m_phase;
  int unsigned m_lfsr;
  int          e_sys2, e_sam, e_sym, e_xz, e_xh, e_idx;

  // samples-per-symbol tracking on the zero-stuffed instance
  bit spp_armed = 1'b0;
  int n_sam     = 0;

  tx_sym_source #(.ZERO_STUFF(1)) dut_zs (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .load_seed   (load_seed),
    .seed        (seed),
    .sys_clk2_en (z_sys2),
    .sam_clk_en  (z_sam),
    .sym_clk_en  (z_sym),
    .x_out       (z_x),
    .sym_idx     (z_idx)
  );

  tx_sym_source #(.ZERO_STUFF(0)) dut_hold (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .load_seed   (load_seed),
    .seed        (seed),
    .sys_clk2_en (h_sys2),
    .sam_clk_en  (h_sam),
    .sym_clk_en  (h_sym),
    .x_out       (h_x),
    .sym_idx     (h_idx)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int level(input int s);
    case (s)
      0:       return -HI;
      1:       return -LO;
      3:       return LO;
      default: return HI;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      $error("%s", tag);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_lfsr  = 1;
    e_sys2 = 0; e_sam = 0; e_sym = 0; e_xz = 0; e_xh = 0; e_idx = 0;
  endtask

  function automatic int next_bit();
    int b;
    b      = int'(((m_lfsr >> 21) ^ (m_lfsr >> 20)) & 1);
    m_lfsr = ((m_lfsr << 1) | b) & 32'h003F_FFFF;
    return b;
  endfunction

  // One sys_clk edge of the sample/symbol schedule, from the inputs at that edge.
  task automatic model_edge();
    int b1, b2;
    if (load_seed) begin
      m_phase = 0;
      m_lfsr  = (seed == 0) ? 1 : int'(seed);
      e_sys2 = 0; e_sam = 0; e_sym = 0; e_xz = 0; e_xh = 0;
    end else if (!enable) begin
      e_sys2 = 0; e_sam = 0; e_sym = 0;
    end else begin
      e_sys2 = int'(m_phase % 2 == 1);
      e_sam  = int'(m_phase % SAM == SAM - 1);
      e_sym  = int'(m_phase == N - 1);
      if (e_sym != 0) begin
        b1    = next_bit();
        b2    = next_bit();
        e_idx = b1 * 2 + b2;
        e_xz  = level(e_idx);
        e_xh  = e_xz;
      end else if (e_sam != 0) begin
        e_xz = 0;
      end
      m_phase = (m_phase + 1) % N;
    end
  endtask

  task automatic check_all();
    chk("zs_sys_clk2_en", int'(z_sys2), e_sys2);
    chk("zs_sam_clk_en",  int'(z_sam),  e_sam);
    chk("zs_sym_clk_en",  int'(z_sym),  e_sym);
    chk("zs_x_out",       int'($signed(z_x)), e_xz);
    chk("zs_sym_idx",     int'(z_idx),  e_idx);
    chk("hold_sys_clk2_en", int'(h_sys2), e_sys2);
    chk("hold_sam_clk_en",  int'(h_sam),  e_sam);
    chk("hold_sym_clk_en",  int'(h_sym),  e_sym);
    chk("hold_x_out",       int'($signed(h_x)), e_xh);
    chk("hold_sym_idx",     int'(h_idx),  e_idx);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    if (reset_n) model_edge();
    #1;
    check_all();
    if (load_seed || !reset_n) begin
      spp_armed = 1'b0;
      n_sam     = 0;
    end else begin
      if (z_sym) begin
        if (spp_armed) chk("samples_per_symbol", n_sam, SYM);
        spp_armed = 1'b1;
        n_sam     = 0;
      end
      if (z_sam) n_sam++;
    end
  endtask

  task automatic wait_phase(input int p, input string tag);
    int k = 0;
    while (m_phase != p && k < 4 * N) begin
      tick();
      k++;
    end
    if (m_phase != p) begin
      checks++;
      failures++;
      $display("FAIL %s timeout observed_phase=%0d expected_phase=%0d", tag, m_phase, p);
    end
  endtask

  // First 40 cycles after a reset release: enable cadence and seed-1 symbol.
  task automatic run_from_reset(input string tag);
    int first_sys2, first_sam, first_sym;
    first_sys2 = 0; first_sam = 0; first_sym = 0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (z_sys2 && first_sys2 == 0) first_sys2 = c;
      if (z_sam && first_sam == 0)   first_sam  = c;
      if (z_sym && first_sym == 0)   first_sym  = c;
      if (c == 16) chk({tag, "_first_level"}, int'($signed(z_x)), -HI);
      if (c == 20 || c == 24 || c == 28) chk({tag, "_stuffed_zero"}, int'($signed(z_x)), 0);
      if (c == 24) chk({tag, "_held_level"}, int'($signed(h_x)), -HI);
    end
    chk({tag, "_first_sys_clk2_en"}, first_sys2, 2);
    chk({tag, "_first_sam_clk_en"},  first_sam,  4);
    chk({tag, "_first_sym_clk_en"},  first_sym,  16);
  endtask

  initial begin
    int   gap;
    logic [17:0] frozen_z, frozen_h;

    // reset state
    model_reset();
    enable = 1'b1;
    repeat (3) tick();

    // cadence and first seed-1 symbols, then a long seed-1 run
    run_from_reset("t1");
    repeat (16000) tick();

    // forced seed 22'h300000
    load_seed = 1'b1;
    seed      = 22'h300000;
    tick();
    load_seed = 1'b0;
    repeat (200) tick();

    // enable low for 7 cycles mid-symbol
    wait_phase(6, "t4_wait");
    frozen_z = z_x;
    frozen_h = h_x;
    enable   = 1'b0;
    repeat (7) begin
      tick();
      chk("t4_frozen_zs",   int'(z_x), int'(frozen_z));
      chk("t4_frozen_hold", int'(h_x), int'(frozen_h));
    end
    enable = 1'b1;
    repeat (100) tick();

    // random enable gaps and occasional reseeding
    for (int i = 0; i < 6000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) begin
        load_seed = 1'b1;
        seed      = 22'($urandom());
      end else begin
        load_seed = 1'b0;
      end
      tick();
    end
    enable    = 1'b1;
    load_seed = 1'b0;

    // seed 0 loaded exactly on a symbol boundary
    wait_phase(N - 1, "t5_wait");
    load_seed = 1'b1;
    seed      = '0;
    tick();
    chk("t5_no_symbol_on_load", int'(z_sym), 0);
    load_seed = 1'b0;
    gap = 0;
    while (gap < 3 * N) begin
      tick();
      gap++;
      if (z_sym) break;
    end
    chk("t5_gap_to_next_symbol", gap, N);
    chk("t5_seed1_level", int'($signed(z_x)), -HI);
    repeat (64) tick();

    // asynchronous reset pulse mid-symbol, between edges
    wait_phase(8, "t6_wait");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_sys_clk2_en", int'(z_sys2), 0);
    chk("t6_async_sam_clk_en",  int'(z_sam),  0);
    chk("t6_async_sym_clk_en",  int'(z_sym),  0);
    chk("t6_async_x_out",       int'(h_x),    0);
    chk("t6_async_sym_idx",     int'(z_idx),  0);
    model_reset();
    spp_armed = 1'b0;
    n_sam     = 0;
    tick();
    run_from_reset("t6");
    repeat (200) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
